pdm_tx: RTL and testbench

Transmit-side PDM source: accepts signed PCM samples over a valid/ready stream and emits a PDM clock plus a second-order sigma-delta bitstream. The output timing matches the front-end sampler, which registers data on the PDM clock rising edge. Used as an on-chip microphone model for loopback and DFE self-test, and as a PDM DAC output. Runs entirely in the system clock domain.

---
 rtl/pdm_tx_pkg.sv | 27 ++
 rtl/pdm_tx_sd_mod2.sv | 48 ++++
 rtl/pdm_tx.sv | 120 ++++++++++++
 tb/tb_pdm_tx.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pdm_tx_pkg.sv
// Shared DFE constants and arithmetic helpers for the PDM path.
// Used by the transmit modulator, the sampler and the CIC decimator.
package pdm_tx_pkg;

   // System clocks per PDM clock; also the CIC decimation base ratio.
   localparam int PDM_CLK_DIV = 4;

   function automatic int fs_of(input int dw);
      return 1 << (dw - 1);
   endfunction

   function automatic int acc_w_of(input int dw);
      return dw + 4;
   endfunction

   // Symmetric clamp to +/-(2^(w-1)-1); never wraps.
   function automatic longint sat(input longint v, input int w);
      longint lim;
      lim = (longint'(1) <<< (w - 1)) - 1;
      if (v > lim)
         return lim;
      if (v < -lim)
         return -lim;
      return v;
   endfunction

endpackage

// File: rtl/pdm_tx_sd_mod2.sv
// Second-order sigma-delta core: two saturating integrators and a
// sign comparator, advanced once per bit strobe.
module sd_mod2
   import pdm_tx_pkg::*;
#(
   parameter int DATA_W = 16
) (
   input  logic                     clk_i,
   input  logic                     clr_i,
   input  logic                     step_i,
   input  logic signed [DATA_W-1:0] x_i,
   output logic                     pdm_o
);

   localparam int     ACC_W = acc_w_of(DATA_W);
   localparam longint FS    = longint'(fs_of(DATA_W));

   logic signed [ACC_W-1:0] r_i1;
   logic signed [ACC_W-1:0] r_i2;
   logic                    r_bit;

   longint w_fb;
   longint w_i1;
   longint w_i2;

   // Next integrator values with full-scale feedback of the last bit.
   always_comb begin
      w_fb = r_bit ? FS : -FS;
      w_i1 = sat(longint'(r_i1) + longint'(x_i) - w_fb, ACC_W);
      w_i2 = sat(longint'(r_i2) + w_i1 - w_fb, ACC_W);
   end

   // Integrator and output bit state, updated only on bit strobes.
   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         r_i1  <= '0;
         r_i2  <= '0;
         r_bit <= 1'b0;
      end else if (step_i) begin
         r_i1  <= ACC_W'(w_i1);
         r_i2  <= ACC_W'(w_i2);
         r_bit <= (w_i2 >= 0);
      end
   end

   assign pdm_o = r_bit;

endmodule

// File: rtl/pdm_tx.sv
// PDM transmitter: PDM clock divider, one-deep sample queue, frame
// counter and the sigma-delta modulator, all in the system clock domain.
module pdm_tx
   import pdm_tx_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int CLK_DIV = PDM_CLK_DIV,
   parameter int OSR     = 250
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     en_i,
   input  logic signed [DATA_W-1:0] data_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   output logic                     pdm_clk_o,
   output logic                     pdm_data_o,
   output logic                     underflow_o
);

   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int CNT_W = $clog2(OSR);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HI   = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

   logic                     r_run;
   logic [DIV_W-1:0]         r_div;
   logic                     r_pdm_clk;
   logic [CNT_W-1:0]         r_bit_cnt;
   logic                     r_primed;
   logic                     r_full;
   logic                     r_uflow;
   logic signed [DATA_W-1:0] r_cur;
   logic signed [DATA_W-1:0] r_next;

   logic                     w_clr;
   logic [DIV_W-1:0]         w_div_nxt;
   logic                     w_step;
   logic                     w_frame_end;
   logic                     w_load;
   logic                     w_accept;
   logic signed [DATA_W-1:0] w_x;

   assign w_clr       = rst_i | ~en_i;
   assign w_step      = r_run & (r_div == DIV_HI);
   assign w_frame_end = r_primed & (r_bit_cnt == CNT_LAST);
   assign w_load      = w_step & r_full & (~r_primed | w_frame_end);
   assign ready_o     = ~w_clr & ~r_full;
   assign w_accept    = valid_i & ready_o;
   assign w_x         = r_primed ? r_cur : '0;

   // Divider holds at 0 for the first running cycle, then wraps.
   always_comb begin
      w_div_nxt = '0;
      if (r_run && r_div != DIV_LAST)
         w_div_nxt = r_div + 1'b1;
   end

   // PDM clock: high for the first half of each divider period.
   always_ff @(posedge clk_i) begin
      if (w_clr) begin
         r_run     <= 1'b0;
         r_div     <= '0;
         r_pdm_clk <= 1'b0;
      end else begin
         r_run     <= 1'b1;
         r_div     <= w_div_nxt;
         r_pdm_clk <= (w_div_nxt <= DIV_HI);
      end
   end

   // Sample queue, priming, frame counting and underflow detection.
   always_ff @(posedge clk_i) begin
      if (w_clr) begin
         r_bit_cnt <= '0;
         r_primed  <= 1'b0;
         r_full    <= 1'b0;
         r_uflow   <= 1'b0;
         r_cur     <= '0;
         r_next    <= '0;
      end else begin
         r_uflow <= w_step & w_frame_end & ~r_full;
         if (w_load)
            r_cur <= r_next;
         if (w_step) begin
            if (!r_primed) begin
               if (r_full) begin
                  r_primed  <= 1'b1;
                  r_bit_cnt <= '0;
               end
            end else if (w_frame_end) begin
               r_bit_cnt <= '0;
            end else begin
               r_bit_cnt <= r_bit_cnt + 1'b1;
            end
         end
         if (w_accept) begin
            r_next <= data_i;
            r_full <= 1'b1;
         end else if (w_load) begin
            r_full <= 1'b0;
         end
      end
   end

   sd_mod2 #(
      .DATA_W (DATA_W)
   ) u_mod (
      .clk_i  (clk_i),
      .clr_i  (w_clr),
      .step_i (w_step),
      .x_i    (w_x),
      .pdm_o  (pdm_data_o)
   );

   assign pdm_clk_o   = r_pdm_clk;
   assign underflow_o = r_uflow;

endmodule

// File: tb/tb_pdm_tx.sv
// Bench for pdm_tx: cycle reference model with a sample scoreboard,
// plus directed density, handshake, underflow and clear checks.
module tb_pdm_tx;

   localparam int     DATA_W  = 16;
   localparam int     CLK_DIV = 4;
   localparam int     OSR     = 250;
   localparam int     HALF    = CLK_DIV / 2;
   localparam longint FS      = 32768;
   localparam longint LIM     = 524287;

   logic                     clk = 1'b0;
   logic                     rst_i;
   logic                     en_i;
   logic signed [DATA_W-1:0] data_i;
   logic                     valid_i;
   logic                     ready_o;
   logic                     pdm_clk_o;
   logic                     pdm_data_o;
   logic                     underflow_o;

   int errors = 0;
   int checks = 0;
   int n_bits = 0;
   int n_ones = 0;
   int n_uf   = 0;
   int n_acc  = 0;

   pdm_tx #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV),
      .OSR     (OSR)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .en_i        (en_i),
      .data_i      (data_i),
      .valid_i     (valid_i),
      .ready_o     (ready_o),
      .pdm_clk_o   (pdm_clk_o),
      .pdm_data_o  (pdm_data_o),
      .underflow_o (underflow_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic longint satb(input longint v);
      if (v > LIM)
         return LIM;
      if (v < -LIM)
         return -LIM;
      return v;
   endfunction

   // Ones density must be (FS+x)/(2FS) within 0.5 %.
   task automatic dens_chk(input string tag, input longint x);
      longint lhs;
      longint rhs;
      longint tol;
      lhs = longint'(n_ones) * 2 * FS;
      rhs = longint'(n_bits) * (FS + x);
      tol = longint'(n_bits) * 2 * FS / 200;
      checks++;
      assert ((lhs - rhs <= tol) && (rhs - lhs <= tol)) else begin
         errors++;
         $error("FAIL %s ones=%0d of %0d bits, required about %0d",
                tag, n_ones, n_bits, rhs / (2 * FS));
      end
   endtask

   // Front-end sampler model: registers data on the PDM clock rise.
   logic r_cap = 1'b0;
   always @(posedge pdm_clk_o)
      r_cap <= pdm_data_o;

   // Reference model state (value after the most recent clk edge).
   bit     m_valid = 0;
   bit     m_run, m_clk, m_bit, m_uf, m_primed;
   int     m_div, m_cnt;
   longint m_cur, m_i1, m_i2;
   longint sb[$];
   bit     p_clr = 1, p_clk = 0, p_data = 0;

   always @(negedge clk) begin
      bit     clr;
      bit     stp;
      bit     rdy;
      longint x;
      longint fb;
      clr = rst_i || !en_i;
      rdy = !clr && (sb.size() == 0);
      if (m_valid) begin
         chk("pdm_clk", 32'(pdm_clk_o), 32'(m_clk));
         chk("pdm_data", 32'(pdm_data_o), 32'(m_bit));
         chk("underflow", 32'(underflow_o), 32'(m_uf));
         chk("ready", 32'(ready_o), 32'(rdy));
         if (!p_clr && pdm_data_o !== p_data)
            chk("data_edge", 32'({p_clk, pdm_clk_o}), 32'(2'b10));
         if (pdm_clk_o)
            chk("sampler", 32'(r_cap), 32'(pdm_data_o));
         if (p_clk && !pdm_clk_o) begin
            n_bits++;
            n_ones += int'(pdm_data_o);
         end
         if (underflow_o)
            n_uf++;
      end
      p_clr  = clr;
      p_clk  = pdm_clk_o;
      p_data = pdm_data_o;
      if (clr) begin
         m_run = 0; m_div = 0; m_clk = 0; m_bit = 0; m_uf = 0;
         m_primed = 0; m_cnt = 0; m_cur = 0; m_i1 = 0; m_i2 = 0;
         sb.delete();
         m_valid = 1;
      end else begin
         stp  = m_run && (m_div == HALF - 1);
         m_uf = 0;
         if (stp) begin
            x    = m_primed ? m_cur : 0;
            fb   = m_bit ? FS : -FS;
            m_i1 = satb(m_i1 + x - fb);
            m_i2 = satb(m_i2 + m_i1 - fb);
            m_bit = (m_i2 >= 0);
            if (!m_primed) begin
               if (sb.size() > 0) begin
                  m_cur = sb.pop_front();
                  m_primed = 1;
                  m_cnt = 0;
               end
            end else if (m_cnt == OSR - 1) begin
               m_cnt = 0;
               if (sb.size() > 0)
                  m_cur = sb.pop_front();
               else
                  m_uf = 1;
            end else begin
               m_cnt++;
            end
         end
         if (valid_i && rdy)
            sb.push_back(longint'(data_i));
         if (!m_run) begin
            m_run = 1;
            m_div = 0;
         end else begin
            m_div = (m_div + 1) % CLK_DIV;
         end
         m_clk = (m_div < HALF);
      end
   end

   initial begin
      bit rdy;
      rst_i = 1'b1; en_i = 1'b0; valid_i = 1'b0; data_i = '0;
      cyc(3);
      chk("rst_clk", 32'(pdm_clk_o), 32'd0);
      chk("rst_data", 32'(pdm_data_o), 32'd0);
      chk("rst_uf", 32'(underflow_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'd0);

      // Idle: enabled, no samples.
      rst_i = 1'b0; en_i = 1'b1;
      #1;
      chk("ready_rise", 32'(ready_o), 32'd1);
      n_bits = 0; n_ones = 0; n_uf = 0;
      cyc(2000);
      chk("idle_uf", 32'(n_uf), 32'd0);
      chk("idle_bits", 32'(n_bits), 32'd500);

      // Density with the queue kept full.
      valid_i = 1'b1;
      data_i = 16'sd0;
      cyc(2000);
      n_bits = 0; n_ones = 0;
      cyc(10000);
      chk("win_bits", 32'(n_bits), 32'd2500);
      dens_chk("dens_zero", 0);
      data_i = 16'sd16384;
      cyc(3000);
      n_bits = 0; n_ones = 0;
      cyc(10000);
      dens_chk("dens_half_pos", 16384);
      data_i = -16'sd16384;
      cyc(3000);
      n_bits = 0; n_ones = 0; n_uf = 0;
      cyc(10000);
      dens_chk("dens_half_neg", -16384);
      chk("stream_uf", 32'(n_uf), 32'd0);

      // Handshake: valid held, new value on every accept.
      for (int i = 0; i < 7000; i++) begin
         rdy = ready_o;
         if (i == 2000) begin
            n_acc = 0;
            n_uf = 0;
         end
         cyc(1);
         if (rdy) begin
            data_i = data_i + 16'sd1000;
            n_acc++;
         end
      end
      chk("accepts", 32'(n_acc), 32'd5);
      chk("hs_uf", 32'(n_uf), 32'd0);

      // Underflow: one sample after a clear, then nothing.
      valid_i = 1'b0;
      en_i = 1'b0;
      cyc(1);
      en_i = 1'b1;
      valid_i = 1'b1;
      data_i = 16'sd8000;
      cyc(1);
      valid_i = 1'b0;
      cyc(1500);
      n_bits = 0; n_ones = 0; n_uf = 0;
      cyc(4000);
      chk("uf_pulses", 32'(n_uf), 32'd4);
      dens_chk("uf_held", 8000);

      // Saturation: full scale positive, then full scale negative.
      valid_i = 1'b1;
      data_i = 16'sd32767;
      cyc(7000);
      data_i = -16'sd32768;
      cyc(4000);
      n_bits = 0; n_ones = 0;
      cyc(1000);
      chk("sat_low", 32'(n_ones * 100 <= n_bits), 32'd1);

      // Mid-frame clear with a sample queued.
      cyc(137);
      en_i = 1'b0;
      #1;
      chk("clr_ready", 32'(ready_o), 32'd0);
      cyc(1);
      en_i = 1'b1;
      #1;
      chk("clr_clk", 32'(pdm_clk_o), 32'd0);
      chk("clr_data", 32'(pdm_data_o), 32'd0);
      chk("clr_uf", 32'(underflow_o), 32'd0);
      chk("clr_ready_back", 32'(ready_o), 32'd1);
      cyc(200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
